// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the cache data array slice.
package cache_pkg;
   // Top-level sequencer: INIT clears every set, READY serves traffic.
   typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

   // Bytes held by one way of one line.
   function automatic int bytes_per_line(input int cl_size);
      return cl_size / 8;
   endfunction

   // Set-index width; never below one bit.
   function automatic int idx_width(input int idx_cnt);
      return (idx_cnt > 1) ? $clog2(idx_cnt) : 1;
   endfunction
endpackage

// File: rtl/cache_data_array_if.sv
// Read/write request bus of the cache data array.
// CACHE_DATA_ARRAY_PARITY_EN adds the per-way rd_par_err return signal.
interface cache_data_array_if
   import cache_pkg::*;
#(
   parameter int CL_SIZE = 512,
   parameter int WAYS    = 4,
   parameter int IDX_CNT = 8
);
   localparam int IDX_W = idx_width(IDX_CNT);
   localparam int BPL   = bytes_per_line(CL_SIZE);

   logic                    rd_valid;
   logic [IDX_W-1:0]        rd_idx;
   logic                    rd_ready;
   logic                    rd_out_valid;
   logic [CL_SIZE*WAYS-1:0] rd_cl_out;
   logic                    wr_valid;
   logic [IDX_W-1:0]        wr_idx;
   logic [WAYS-1:0]         wr_way_mask;
   logic [BPL-1:0]          wr_byte_en;
   logic [CL_SIZE*WAYS-1:0] wr_data;
   logic                    wr_ready;
   logic                    init_busy;
`ifdef CACHE_DATA_ARRAY_PARITY_EN
   logic [WAYS-1:0]         rd_par_err;

   modport master (
      output rd_valid, rd_idx, wr_valid, wr_idx, wr_way_mask, wr_byte_en, wr_data,
      input  rd_ready, rd_out_valid, rd_cl_out, wr_ready, init_busy, rd_par_err
   );
   modport slave (
      input  rd_valid, rd_idx, wr_valid, wr_idx, wr_way_mask, wr_byte_en, wr_data,
      output rd_ready, rd_out_valid, rd_cl_out, wr_ready, init_busy, rd_par_err
   );
`else
   modport master (
      output rd_valid, rd_idx, wr_valid, wr_idx, wr_way_mask, wr_byte_en, wr_data,
      input  rd_ready, rd_out_valid, rd_cl_out, wr_ready, init_busy
   );
   modport slave (
      input  rd_valid, rd_idx, wr_valid, wr_idx, wr_way_mask, wr_byte_en, wr_data,
      output rd_ready, rd_out_valid, rd_cl_out, wr_ready, init_busy
   );
`endif
endinterface

// File: rtl/cache_byte_merge.sv
// Byte-granular merge of one way: enabled bytes from the new line, the rest from the old.
module cache_byte_merge #(
   parameter int CL_SIZE = 512
) (
   input  logic [CL_SIZE-1:0]   old_line,
   input  logic [CL_SIZE-1:0]   new_line,
   input  logic [CL_SIZE/8-1:0] byte_en,
   output logic [CL_SIZE-1:0]   merged
);
   // Per-byte select between stored and incoming data.
   always_comb begin
      merged = old_line;
      for (int b = 0; b < CL_SIZE/8; b++)
         if (byte_en[b]) merged[b*8 +: 8] = new_line[b*8 +: 8];
   end
endmodule

// File: rtl/cache_data_array.sv
// Set-associative cache data array with self-clearing init, per-way byte writes
// and same-cycle write-to-read forwarding.
// CACHE_DATA_ARRAY_PARITY_EN: store and check one even-parity bit per way per set.
module cache_data_array
   import cache_pkg::*;
#(
   parameter int CL_SIZE = 512,
   parameter int WAYS    = 4,
   parameter int IDX_CNT = 8
) (
   input logic               clk,
   input logic               rst,
   cache_data_array_if.slave bus
);
   localparam int IDX_W = idx_width(IDX_CNT);
   localparam int BPL   = bytes_per_line(CL_SIZE);

   state_t                         state;
   logic [IDX_W-1:0]               cnt;
   logic [CL_SIZE-1:0]             mem [IDX_CNT][WAYS];
   logic [WAYS-1:0][CL_SIZE-1:0]   merged;
   logic [CL_SIZE*WAYS-1:0]        rd_line;
   logic                           rd_fire, wr_fire, fwd;
   logic                           out_valid;
   logic [CL_SIZE*WAYS-1:0]        cl_out;

   assign bus.rd_ready     = (state == READY);
   assign bus.wr_ready     = (state == READY);
   assign bus.init_busy    = (state == INIT);
   assign bus.rd_out_valid = out_valid;
   assign bus.rd_cl_out    = cl_out;

   assign rd_fire = bus.rd_valid && (state == READY);
   assign wr_fire = bus.wr_valid && (state == READY);
   // Same-index read and write in one cycle return post-write contents.
   assign fwd     = rd_fire && wr_fire && (bus.rd_idx == bus.wr_idx);

   // One merge per way; an unselected way merges nothing and keeps its old line.
   for (genvar w = 0; w < WAYS; w++) begin : g_way
      cache_byte_merge #(.CL_SIZE(CL_SIZE)) u_merge (
         .old_line (mem[bus.wr_idx][w]),
         .new_line (bus.wr_data[w*CL_SIZE +: CL_SIZE]),
         .byte_en  (bus.wr_byte_en & {BPL{bus.wr_way_mask[w]}}),
         .merged   (merged[w])
      );
   end

   // Read data source: merged write result when forwarding, else stored line.
   always_comb begin
      rd_line = '0;
      for (int w = 0; w < WAYS; w++)
         rd_line[w*CL_SIZE +: CL_SIZE] = fwd ? merged[w] : mem[bus.rd_idx][w];
   end

   // Init sequencer: walk every set once after reset, then serve traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         case (state)
            INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == IDX_W'(IDX_CNT-1)) state <= READY;
            end
            default: ;
         endcase
      end
   end

   // Array update: zero one set per init cycle, otherwise store merged write lines.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            for (int w = 0; w < WAYS; w++) mem[cnt][w] <= '0;
         end else if (wr_fire) begin
            for (int w = 0; w < WAYS; w++) mem[bus.wr_idx][w] <= merged[w];
         end
      end
   end

   // Read return register: one-cycle pulse, data held between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         cl_out    <= '0;
      end else begin
         out_valid <= rd_fire;
         if (rd_fire) cl_out <= rd_line;
      end
   end

`ifdef CACHE_DATA_ARRAY_PARITY_EN
   logic [WAYS-1:0] par_mem [IDX_CNT];
   logic [WAYS-1:0] par_err;
   logic [WAYS-1:0] par_chk;

   assign bus.rd_par_err = par_err;

   // Stored-line check; a forwarded line is fresh and cannot mismatch.
   always_comb begin
      par_chk = '0;
      for (int w = 0; w < WAYS; w++)
         par_chk[w] = fwd ? 1'b0 : ((^mem[bus.rd_idx][w]) ^ par_mem[bus.rd_idx][w]);
   end

   // Parity store follows the array: cleared on init, recomputed on each write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            par_mem[cnt] <= '0;
         end else if (wr_fire) begin
            for (int w = 0; w < WAYS; w++) par_mem[bus.wr_idx][w] <= ^merged[w];
         end
      end
   end

   // Parity error return, aligned with rd_cl_out.
   always_ff @(posedge clk) begin
      if (rst)          par_err <= '0;
      else if (rd_fire) par_err <= par_chk;
   end
`endif
endmodule

// File: tb/tb_cache_data_array.sv
// Randomized bench for cache_data_array against a byte-level array model.
module tb_cache_data_array;
   localparam int CL  = 512;
   localparam int W   = 4;
   localparam int N   = 8;
   localparam int BPL = CL / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_data_array_if #(.CL_SIZE(CL), .WAYS(W), .IDX_CNT(N)) bus ();
   cache_data_array #(.CL_SIZE(CL), .WAYS(W), .IDX_CNT(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model: plain byte array plus per-way "parity corrupted" flags.
   logic [7:0]     ref_mem [N][W][BPL];
   logic [W-1:0]   ref_bad [N];
   int             init_left;
   logic [CL-1:0]  exp_out [W];
   logic           exp_valid;
   logic [W-1:0]   exp_perr;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [CL-1:0] ref_line(input int i, input int w);
      logic [CL-1:0] l;
      for (int b = 0; b < BPL; b++) l[b*8 +: 8] = ref_mem[i][w][b];
      return l;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         ref_bad[i] = '0;
         for (int w = 0; w < W; w++)
            for (int b = 0; b < BPL; b++) ref_mem[i][w][b] = 8'h00;
      end
   endtask

   // One clock cycle: drive, predict, advance, check.
   task automatic step(input bit r, input bit rv, input int ri, input bit wv, input int wi,
                       input logic [W-1:0] wm, input logic [BPL-1:0] be,
                       input logic [CL*W-1:0] wd);
      bit rdy, acc;
      rst             = r;
      bus.rd_valid    = rv;
      bus.rd_idx      = ri[2:0];
      bus.wr_valid    = wv;
      bus.wr_idx      = wi[2:0];
      bus.wr_way_mask = wm;
      bus.wr_byte_en  = be;
      bus.wr_data     = wd;
      rdy = (init_left == 0);
      acc = rdy && !r;
      chk("rd_ready",  CL'(bus.rd_ready),  CL'(rdy));
      chk("wr_ready",  CL'(bus.wr_ready),  CL'(rdy));
      chk("init_busy", CL'(bus.init_busy), CL'(!rdy));
      if (wv && acc)
         for (int w = 0; w < W; w++)
            if (wm[w]) begin
               if (be != '0) ref_bad[wi][w] = 1'b0;
               for (int b = 0; b < BPL; b++)
                  if (be[b]) ref_mem[wi][w][b] = wd[w*CL + b*8 +: 8];
            end
      exp_valid = rv && acc;
      if (exp_valid) begin
         for (int w = 0; w < W; w++) exp_out[w] = ref_line(ri, w);
         exp_perr = (wv && wi == ri) ? '0 : ref_bad[ri];
      end
      if (r) begin
         model_clear();
         for (int w = 0; w < W; w++) exp_out[w] = '0;
         exp_perr = '0;
      end
      @(posedge clk);
      #1;
      if (r) init_left = N;
      else if (init_left > 0) init_left--;
      chk("rd_out_valid", CL'(bus.rd_out_valid), CL'(exp_valid));
      for (int w = 0; w < W; w++)
         chk($sformatf("rd_cl_out_w%0d", w), bus.rd_cl_out[w*CL +: CL], exp_out[w]);
`ifdef CACHE_DATA_ARRAY_PARITY_EN
      chk("rd_par_err", CL'(bus.rd_par_err), CL'(exp_perr));
`endif
   endtask

   function automatic logic [CL*W-1:0] rand_data();
      logic [CL*W-1:0] d;
      for (int k = 0; k < CL*W/32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [BPL-1:0] rand_be();
      logic [BPL-1:0] e;
      for (int k = 0; k < BPL/32; k++) e[k*32 +: 32] = $urandom;
      return e;
   endfunction

   logic [CL*W-1:0] zd, a5d, x5ad;
   logic [CL-1:0]   a5l, mixl;
   logic [BPL-1:0]  all_be, b0_be;

   initial begin
      zd     = '0;
      a5d    = {(CL*W/8){8'hA5}};
      x5ad   = {(CL*W/8){8'h5A}};
      a5l    = {(CL/8){8'hA5}};
      mixl   = a5l;
      mixl[7:0] = 8'h5A;
      all_be = '1;
      b0_be  = '0;
      b0_be[0] = 1'b1;
      model_clear();
      for (int w = 0; w < W; w++) exp_out[w] = '0;
      exp_valid = 1'b0;
      exp_perr  = '0;
      rst = 1'b1;
      bus.rd_valid = 1'b0; bus.rd_idx = '0; bus.wr_valid = 1'b0; bus.wr_idx = '0;
      bus.wr_way_mask = '0; bus.wr_byte_en = '0; bus.wr_data = '0;
      @(posedge clk);
      #1;
      init_left = N;

      // Reset values, then requests during init must be ignored.
      step(1, 1, 0, 1, 0, '1, all_be, a5d);
      for (int i = 0; i < N; i++) step(0, 1, i, 1, i, '1, all_be, a5d);
      // Every set reads back zero after init.
      for (int i = 0; i < N; i++) step(0, 1, i, 0, 0, '0, '0, zd);

      // Full-line write of way 1 in set 3, read back next cycle.
      step(0, 0, 0, 1, 3, 4'b0010, all_be, a5d);
      step(0, 1, 3, 0, 0, '0, '0, zd);
      chk("set3_way1_a5", bus.rd_cl_out[CL +: CL], a5l);
      chk("set3_way0_zero", bus.rd_cl_out[0 +: CL], '0);
      // Single-byte write forwarded to a same-cycle read.
      step(0, 1, 3, 1, 3, 4'b0010, b0_be, x5ad);
      chk("fwd_byte0", bus.rd_cl_out[CL +: CL], mixl);
      // Empty masks change nothing.
      step(0, 0, 0, 1, 3, '0, all_be, zd);
      step(0, 0, 0, 1, 3, '1, '0, zd);
      step(0, 1, 3, 0, 0, '0, '0, zd);
      // Different indices in the same cycle stay independent.
      step(0, 1, 6, 1, 5, '1, all_be, rand_data());
      step(0, 1, 5, 0, 0, '0, '0, zd);
      step(0, 0, 0, 0, 0, '0, '0, zd);

      // Reset during traffic, then reads during and after init.
      step(0, 1, 3, 1, 4, '1, all_be, rand_data());
      step(1, 1, 3, 1, 3, '1, all_be, a5d);
      for (int i = 0; i < N; i++) step(0, 1, 3, 1, 3, '1, all_be, a5d);
      step(0, 1, 3, 0, 0, '0, '0, zd);
      chk("set3_after_rst", bus.rd_cl_out[CL +: CL], '0);

      // Random traffic with occasional reset.
      for (int n = 0; n < 400; n++)
         step(($urandom_range(99) == 0), $urandom_range(1), $urandom_range(N-1),
              $urandom_range(1), $urandom_range(N-1), W'($urandom),
              ($urandom_range(3) == 0) ? all_be : rand_be(), rand_data());
      for (int i = 0; i < N + 2; i++) step(0, 0, 0, 0, 0, '0, '0, zd);

`ifdef CACHE_DATA_ARRAY_PARITY_EN
      // Corrupt one stored bit in set 2 way 0 behind the array's back.
      step(0, 0, 0, 1, 2, '1, all_be, rand_data());
      dut.mem[2][0][0] = ~dut.mem[2][0][0];
      ref_mem[2][0][0][0] = ~ref_mem[2][0][0][0];
      ref_bad[2][0] = 1'b1;
      step(0, 1, 2, 0, 0, '0, '0, zd);
      chk("par_err_set2", CL'(bus.rd_par_err), CL'(4'b0001));
      // A forwarded read of the same set reports no error.
      step(0, 1, 2, 1, 2, 4'b0010, b0_be, rand_data());
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cache_data_array.md
# cache_data_array

Parametrised set-associative cache data array. It succeeds the single-port line store with per-way, byte-granular writes, byte-merged store forwarding, and a self-clearing initialisation sequencer. It has a ready/valid read and write port and optional per-way parity. It sits between the tag/hit logic (which supplies set index and way/byte masks) and the load-return and fill paths of the cache.

## Interface
- CL_SIZE, 512: bits per cache line per way; multiple of 8.
- WAYS, 4: ways per set.
- IDX_CNT, 8: number of sets; power of two, ≥2.
- IDX_W, $clog2(IDX_CNT): set-index width (derived).
- BPL, CL_SIZE/8: bytes per line (derived).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_valid  in  1  read request.
- rd_idx  in  IDX_W  set to read.
- rd_ready  out  1  read port can accept.
- rd_out_valid  out  1  rd_cl_out carries a fresh result.
- rd_cl_out  out  CL_SIZE*WAYS  all ways of the set; way w at bits [w*CL_SIZE +: CL_SIZE].
- wr_valid  in  1  write request.
- wr_idx  in  IDX_W  set to write.
- wr_way_mask  in  WAYS  ways written.
- wr_byte_en  in  BPL  byte enables, applied identically to every selected way.
- wr_data  in  CL_SIZE*WAYS  write data, same way layout as rd_cl_out.
- wr_ready  out  1  write port can accept.
- init_busy  out  1  clear sequence in progress.
- rd_par_err  out  WAYS  per-way parity error (only with parity enabled; otherwise absent).

## Operation
- FSM states: INIT, READY.
- In INIT, a counter walks sets 0..IDX_CNT-1, one set per cycle. Each cycle writes zero to all ways of that set, and clears its parity.
- After set IDX_CNT-1 is cleared, the FSM moves to READY.
- rst forces state INIT and counter 0, including mid-sequence or mid-traffic. Any request in flight is discarded.
- rd_ready = wr_ready = (state == READY).
- Requests are accepted only on valid&ready. Requests presented in INIT are ignored, not queued.
- Write: for each way w with wr_way_mask[w]=1 and each byte b with wr_byte_en[b]=1, array byte is replaced by the wr_data byte. Other bytes and ways are unchanged.
- A write with an all-zero way mask or byte mask is accepted and changes nothing.
- Read returns every way of rd_idx.
- Forwarding: a read and a write accepted in the same cycle to the same index return the merged data, byte-by-byte per way, i.e. post-write contents.
- Same-cycle read and write to different indices are independent.
- rd_cl_out holds its last value when no read is accepted. rd_out_valid is a one-cycle pulse per accepted read.

## Timing
- Reset values: rd_out_valid=0, rd_cl_out=0, rd_par_err=0, init_busy=1, rd_ready=wr_ready=0.
- First cycle with rst low is INIT with counter 0. init_busy stays 1 for exactly IDX_CNT cycles after rst deasserts, then falls.
- Read accepted in cycle N: result valid in cycle N+1, 1-cycle latency, full throughput.
- Write accepted in cycle N: visible in the array to reads accepted in N+1 onward, and via forwarding to a read in N.
- No back-pressure in READY. The block never stalls.

## Configuration
- CACHE_DATA_ARRAY_PARITY_EN defined:
  - one even-parity bit per way per set is stored, recomputed over the full merged line on every write and on init.
  - On read, rd_par_err[w] is 1 in cycle N+1 if the stored parity mismatches the stored line.
  - Forwarded reads use freshly computed parity, so rd_par_err=0.
- Undefined: no parity storage, rd_par_err port absent, no check logic.

## Structure
- Shared package cache_pkg: the INIT/READY state enum, and helper constants for byte count and index width.
- One sub-module, cache_byte_merge. It is combinational and computes old/new/byte-enable merge for one way. It is instantiated WAYS times, and the merged result feeds both the array write and the forwarding path.
- The FSM, counter, array and output registers live in the top module.

## Test plan
- Reset, then read every set -> rd_ready low for 8 cycles. All reads afterwards return 0 and rd_par_err=0.
- Write set 3, way mask 4'b0010, byte_en all-ones, data 0xA5 repeated; read set 3 next cycle -> way1 all 0xA5, ways 0/2/3 zero.
- Same set, byte_en with only bit 0 set, data byte 0x5A, read in the same cycle -> output byte 0 of way1=0x5A, bytes 1..63=0xA5.
- Write set 5 and read set 6 in the same cycle -> read returns set-6 contents unchanged. Set 5 is updated next cycle.
- Assert rst for 1 cycle during traffic, then read set 3 after init -> all zero. Requests during INIT are not acknowledged.
- With parity enabled, force one stored data bit flip in set 2 way 0 via backdoor, then read -> rd_par_err=4'b0001 one cycle later.
